lcb_word_packer: RTL

Byte-to-word packer between the LCB UART receiver and the ping-pong orbit RAMs. Pairs consecutive received bytes into 12-bit orbit words, writes them at incrementing addresses into the bank not currently read by the orbit framer, and restarts at address 0 on every bank swap. Flags malformed bytes, stalled half-words and bank overflow.

---
 rtl/lcb_pkg.sv | 11 +
 rtl/lcb_gap_timer.sv | 27 ++
 rtl/lcb_word_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lcb_pkg.sv
// Shared widths and FSM state type for the LCB byte-to-word packer.
package lcb_pkg;
  localparam int unsigned WORD_W = 12;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 12;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } lcbState_t;
endpackage

// File: rtl/lcb_gap_timer.sv
// Half-word timeout: counts enabled cycles since clear, pulses expire on the GAP_CYCLES-th.
module lcb_gap_timer #(
  parameter int unsigned GAP_CYCLES = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int unsigned CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/lcb_word_packer.sv
// Pairs UART bytes into 12-bit orbit words for the ping-pong RAM bank not being read.
// Optional half-word timeout enabled by defining LCB_GAP_TIMEOUT_EN.
module lcb_word_packer
  import lcb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned GAP_CYCLES = 16000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              sw,
  output logic [WORD_W-1:0] word,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              ovf,
  output logic              fmt_err,
  output logic              gap_err
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 1 || DEPTH > 2048 || GAP_CYCLES < 1) begin : gParamCheck
    $error("lcb_word_packer: DEPTH must be 1..2048 and GAP_CYCLES >= 1");
  end

  lcbState_t         state, stateNext;
  logic [3:0]        hiNib, hiNext;
  logic              swReg, swArmed, swap;
  logic [WORD_W-1:0] wordNext;
  logic [ADDR_W-1:0] addrNext;
  logic [CNT_W-1:0]  cntNext, baseCnt;
  logic              weNext, ovfNext, fmtNext, gapNext;
  logic              gapExpire;

`ifdef LCB_GAP_TIMEOUT_EN
  logic timerClr, timerEn;

  lcb_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) uGapTimer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timerClr),
    .en     (timerEn),
    .expire (gapExpire)
  );
`else
  assign gapExpire = 1'b0;
`endif

  // swArmed masks the first cycle after reset so the sw copy can load without a false swap.
  assign swap    = swArmed && (sw != swReg);
  assign baseCnt = swap ? '0 : word_cnt;

  always_comb begin
    stateNext = state;
    hiNext    = hiNib;
    weNext    = 1'b0;
    wordNext  = word;
    addrNext  = wr_addr;
    cntNext   = baseCnt;
    ovfNext   = swap ? 1'b0 : ovf;
    fmtNext   = 1'b0;
    gapNext   = 1'b0;
`ifdef LCB_GAP_TIMEOUT_EN
    timerClr  = 1'b0;
    timerEn   = 1'b0;
`endif
    unique case (state)
      WAIT_HI: begin
        if (rx_valid && !swap) begin
          hiNext    = rx_data[3:0];
          fmtNext   = |rx_data[7:4];
          stateNext = WAIT_LO;
`ifdef LCB_GAP_TIMEOUT_EN
          timerClr  = 1'b1;
`endif
        end
      end
      WAIT_LO: begin
        // A low byte arriving with a swap still lands, at address 0 of the new bank.
        if (rx_valid) begin
          if (baseCnt < DEPTH_C) begin
            weNext   = 1'b1;
            wordNext = {hiNib, rx_data};
            addrNext = baseCnt[ADDR_W-1:0];
            cntNext  = baseCnt + CNT_W'(1);
          end else begin
            ovfNext  = 1'b1;
          end
          stateNext = WAIT_HI;
        end else if (swap) begin
          stateNext = WAIT_HI;
        end else begin
`ifdef LCB_GAP_TIMEOUT_EN
          timerEn = 1'b1;
`endif
          if (gapExpire) begin
            gapNext   = 1'b1;
            stateNext = WAIT_HI;
          end
        end
      end
      default: stateNext = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WAIT_HI;
      hiNib    <= '0;
      swReg    <= 1'b0;
      swArmed  <= 1'b0;
      word     <= '0;
      we       <= 1'b0;
      wr_addr  <= '0;
      word_cnt <= '0;
      ovf      <= 1'b0;
      fmt_err  <= 1'b0;
      gap_err  <= 1'b0;
    end else begin
      state    <= stateNext;
      hiNib    <= hiNext;
      swReg    <= sw;
      swArmed  <= 1'b1;
      word     <= wordNext;
      we       <= weNext;
      wr_addr  <= addrNext;
      word_cnt <= cntNext;
      ovf      <= ovfNext;
      fmt_err  <= fmtNext;
      gap_err  <= gapNext;
    end
  end
endmodule
